// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module      : dmem_arbiter
// Description : Single-port data memory arbiter. The pipeline MEM port (P) has
//               priority over the debug/loader port (D). A saturating
//               starvation counter forces a D grant, and a lock mode lets D
//               own the memory exclusively. Read data is routed back to the
//               port that issued the read, one cycle after the strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter #(
  parameter int unsigned STARVE_MAX = 8,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_p_req,
  input  logic              i_p_wren,
  input  logic [ADDR_W-1:0] i_p_addr,
  input  logic [31:0]       i_p_wdata,
  input  logic [3:0]        i_p_bmask,
  output logic              o_p_stall,
  output logic              o_p_rvalid,
  output logic [31:0]       o_p_rdata,
  input  logic              i_d_req,
  input  logic              i_d_wren,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [31:0]       i_d_wdata,
  input  logic [3:0]        i_d_bmask,
  input  logic              i_d_lock,
  output logic              o_d_gnt,
  output logic              o_d_rvalid,
  output logic [31:0]       o_d_rdata,
  output logic              o_m_req,
  output logic              o_m_wren,
  output logic [ADDR_W-1:0] o_m_addr,
  output logic [31:0]       o_m_wdata,
  output logic [3:0]        o_m_bmask,
  input  logic [31:0]       i_m_rdata
);

  localparam logic [0:0] c_st_arb  = 1'b0;
  localparam logic [0:0] c_st_lock = 1'b1;
  localparam logic [7:0] c_starve_max = 8'(STARVE_MAX);

  logic [0:0] state_q, state_d;
  logic [7:0] starve_q, starve_d;
  logic       rd_pend_q, rd_pend_d;   // a read was strobed last cycle
  logic       rd_own_d_q, rd_own_d_d; // owner of that read: 1 = D, 0 = P
  logic       w_gnt_p;
  logic       w_gnt_d;

  // State, starvation counter and read-owner tag registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= c_st_arb;
      starve_q   <= 8'd0;
      rd_pend_q  <= 1'b0;
      rd_own_d_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      rd_pend_q  <= rd_pend_d;
      rd_own_d_q <= rd_own_d_d;
    end
  end

  // Next-state: lock is entered only on an actual D grant, left when lock drops
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_st_arb:  if (w_gnt_d && i_d_lock) state_d = c_st_lock;
      c_st_lock: if (!i_d_lock)           state_d = c_st_arb;
      default:                            state_d = c_st_arb;
    endcase
  end

  // Grant decision; everything is forced idle while reset is held
  always_comb begin
    w_gnt_p = 1'b0;
    w_gnt_d = 1'b0;
    if (!i_rst) begin
      if (state_q == c_st_lock) begin
        w_gnt_d = i_d_req;
      end else begin
        w_gnt_d = i_d_req && (!i_p_req || (starve_q == c_starve_max));
        w_gnt_p = i_p_req && !w_gnt_d;
      end
    end
  end

  // Counter and read-tag next values follow from the grant of this cycle
  always_comb begin
    starve_d   = 8'd0;
    rd_pend_d  = 1'b0;
    rd_own_d_d = 1'b0;
    if (state_q == c_st_arb && i_d_req && !w_gnt_d) begin
      starve_d = (starve_q >= c_starve_max) ? c_starve_max : starve_q + 8'd1;
    end
    if (w_gnt_d && !i_d_wren) begin
      rd_pend_d  = 1'b1;
      rd_own_d_d = 1'b1;
    end else if (w_gnt_p && !i_p_wren) begin
      rd_pend_d  = 1'b1;
    end
  end

  // Memory-side mux and port-side status/response outputs
  always_comb begin
    o_m_req   = w_gnt_p | w_gnt_d;
    o_m_wren  = 1'b0;
    o_m_addr  = '0;
    o_m_wdata = 32'd0;
    o_m_bmask = 4'd0;
    if (w_gnt_d) begin
      o_m_wren  = i_d_wren;
      o_m_addr  = i_d_addr;
      o_m_wdata = i_d_wdata;
      o_m_bmask = i_d_bmask;
    end else if (w_gnt_p) begin
      o_m_wren  = i_p_wren;
      o_m_addr  = i_p_addr;
      o_m_wdata = i_p_wdata;
      o_m_bmask = i_p_bmask;
    end
    o_p_stall  = !i_rst && i_p_req && !w_gnt_p;
    o_d_gnt    = w_gnt_d;
    // An in-flight read is dropped if reset arrives before its data
    o_p_rvalid = !i_rst && rd_pend_q && !rd_own_d_q;
    o_d_rvalid = !i_rst && rd_pend_q &&  rd_own_d_q;
    o_p_rdata  = o_p_rvalid ? i_m_rdata : 32'd0;
    o_d_rdata  = o_d_rvalid ? i_m_rdata : 32'd0;
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Self-checking bench for dmem_arbiter: directed scenarios
//               followed by random traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

  localparam int SMAX = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        p_req, p_wren, d_req, d_wren, d_lock;
  logic [31:0] p_addr, p_wdata, d_addr, d_wdata, m_rdata;
  logic [3:0]  p_bmask, d_bmask;
  logic        p_stall, p_rvalid, d_gnt, d_rvalid, m_req, m_wren;
  logic [31:0] p_rdata, d_rdata, m_addr, m_wdata;
  logic [3:0]  m_bmask;

  int checks = 0;
  int errors = 0;

  // Behavioural model: lock flag, length of current D denial streak,
  // and who (0 none, 1 P, 2 D) is owed read data this cycle.
  bit m_locked = 0;
  int m_deny   = 0;
  int m_pend   = 0;
  bit e_gp, e_gd;

  dmem_arbiter #(.STARVE_MAX(SMAX), .ADDR_W(32)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_p_req(p_req), .i_p_wren(p_wren), .i_p_addr(p_addr),
    .i_p_wdata(p_wdata), .i_p_bmask(p_bmask),
    .o_p_stall(p_stall), .o_p_rvalid(p_rvalid), .o_p_rdata(p_rdata),
    .i_d_req(d_req), .i_d_wren(d_wren), .i_d_addr(d_addr),
    .i_d_wdata(d_wdata), .i_d_bmask(d_bmask), .i_d_lock(d_lock),
    .o_d_gnt(d_gnt), .o_d_rvalid(d_rvalid), .o_d_rdata(d_rdata),
    .o_m_req(m_req), .o_m_wren(m_wren), .o_m_addr(m_addr),
    .o_m_wdata(m_wdata), .o_m_bmask(m_bmask), .i_m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model, mid-cycle
  task automatic sample();
    logic [31:0] ea, ew;
    logic [3:0]  eb;
    logic        er;
    @(negedge clk);
    e_gp = 0; e_gd = 0;
    if (!rst) begin
      if (m_locked) e_gd = d_req;
      else begin
        e_gd = d_req && (!p_req || m_deny >= SMAX);
        e_gp = p_req && !e_gd;
      end
    end
    ea = e_gd ? d_addr  : (e_gp ? p_addr  : 32'd0);
    ew = e_gd ? d_wdata : (e_gp ? p_wdata : 32'd0);
    eb = e_gd ? d_bmask : (e_gp ? p_bmask : 4'd0);
    er = e_gd ? d_wren  : (e_gp ? p_wren  : 1'b0);
    chk("m_req",   {31'd0, m_req},   {31'd0, e_gp | e_gd});
    chk("m_wren",  {31'd0, m_wren},  {31'd0, er});
    chk("m_addr",  m_addr,  ea);
    chk("m_wdata", m_wdata, ew);
    chk("m_bmask", {28'd0, m_bmask}, {28'd0, eb});
    chk("d_gnt",   {31'd0, d_gnt},   {31'd0, e_gd});
    chk("p_stall", {31'd0, p_stall}, {31'd0, !rst && p_req && !e_gp});
    chk("p_rvalid", {31'd0, p_rvalid}, {31'd0, !rst && m_pend == 1});
    chk("d_rvalid", {31'd0, d_rvalid}, {31'd0, !rst && m_pend == 2});
    chk("p_rdata", p_rdata, (!rst && m_pend == 1) ? m_rdata : 32'd0);
    chk("d_rdata", d_rdata, (!rst && m_pend == 2) ? m_rdata : 32'd0);
  endtask

  // Advance one clock and update the model from this cycle's decisions
  task automatic edge_step();
    @(posedge clk);
    if (rst) begin
      m_locked = 0; m_deny = 0; m_pend = 0;
    end else begin
      if (e_gd && !d_wren)      m_pend = 2;
      else if (e_gp && !p_wren) m_pend = 1;
      else                      m_pend = 0;
      if (m_locked) begin
        m_deny = 0;
        if (!d_lock) m_locked = 0;
      end else begin
        m_deny = (d_req && !e_gd) ? ((m_deny + 1 > SMAX) ? SMAX : m_deny + 1) : 0;
        if (e_gd && d_lock) m_locked = 1;
      end
    end
    #1;
    m_rdata = $urandom;
  endtask

  task automatic cyc();
    sample();
    edge_step();
  endtask

  task automatic idle();
    p_req = 0; p_wren = 0; p_addr = 0; p_wdata = 0; p_bmask = 0;
    d_req = 0; d_wren = 0; d_addr = 0; d_wdata = 0; d_bmask = 0; d_lock = 0;
  endtask

  initial begin
    idle();
    m_rdata = 32'd0;
    // 1: reset held with both ports requesting
    rst = 1; p_req = 1; d_req = 1;
    repeat (3) begin
      sample();
      chk("rst_m_req", {31'd0, m_req}, 32'd0);
      edge_step();
    end
    rst = 0;
    sample();
    chk("post_rst_p_gnt", {31'd0, m_req & ~p_stall & ~d_gnt}, 32'd1);
    edge_step();

    // 2: P read, data returned next cycle
    idle();
    p_req = 1; p_addr = 32'h100; p_bmask = 4'hF;
    cyc();
    p_req = 0; m_rdata = 32'hDEADBEEF;
    sample();
    chk("p_read_data", p_rdata, 32'hDEADBEEF);
    chk("p_read_dvld", {31'd0, d_rvalid}, 32'd0);
    edge_step();

    // 3: continuous contention, D every 9th cycle
    p_req = 1; p_wren = 1; d_req = 1; d_wren = 1; d_addr = 32'h40;
    for (int k = 0; k < 18; k++) begin
      sample();
      chk("starve_pattern", {31'd0, d_gnt}, {31'd0, (k % 9) == 8});
      edge_step();
    end

    // 4: D write while P idle
    idle();
    d_req = 1; d_wren = 1; d_addr = 32'h200; d_wdata = 32'h12345678; d_bmask = 4'hF;
    sample();
    chk("d_wr_gnt",  {31'd0, d_gnt}, 32'd1);
    chk("d_wr_addr", m_addr, 32'h200);
    chk("d_wr_wren", {31'd0, m_wren}, 32'd1);
    edge_step();
    idle();
    sample();
    chk("d_wr_norv", {30'd0, p_rvalid, d_rvalid}, 32'd0);
    edge_step();

    // 5: lock for 5 cycles while P requests, then release
    d_req = 1; d_lock = 1; d_wren = 1;
    cyc();
    p_req = 1; p_addr = 32'h300;
    repeat (5) begin
      sample();
      chk("lock_stall", {31'd0, p_stall}, 32'd1);
      edge_step();
    end
    d_req = 0; d_lock = 0;
    cyc();
    sample();
    chk("unlock_p_gnt", {31'd0, p_stall}, 32'd0);
    edge_step();

    // 6: reset right after a D read grant
    idle();
    d_req = 1; d_addr = 32'h80;
    cyc();
    idle();
    rst = 1;
    sample();
    chk("rst_drop_dvld", {31'd0, d_rvalid}, 32'd0);
    edge_step();
    rst = 0; p_req = 1; d_req = 1;
    sample();
    chk("rst6_p_first", {31'd0, d_gnt}, 32'd0);
    edge_step();
    sample();
    chk("rst6_dvld", {31'd0, d_rvalid}, 32'd0);
    edge_step();

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      rst     = ($urandom_range(0, 60) == 0);
      p_req   = ($urandom_range(0, 3) != 0);
      p_wren  = $urandom_range(0, 1);
      p_addr  = $urandom;
      p_wdata = $urandom;
      p_bmask = 4'($urandom);
      d_req   = $urandom_range(0, 1);
      d_wren  = $urandom_range(0, 1);
      d_addr  = $urandom;
      d_wdata = $urandom;
      d_bmask = 4'($urandom);
      d_lock  = ($urandom_range(0, 4) == 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sits between the pipeline MEM stage and the single-ported data memory.
- Arbitrates each cycle between the pipeline MEM-stage port (P) and a debug/loader port (D). D is used for program load, memory inspection and self-check.
- P has priority. A starvation counter guarantees D forward progress.
- A lock mode lets D halt all pipeline memory traffic for bulk transfers.
- o_p_stall feeds the hazard unit to stall the pipeline while P is not granted.

Parameters:
- STARVE_MAX, 8: consecutive cycles D may be denied while requesting before a forced D grant. Range 1..255.
- ADDR_W, 32: address width of both ports and of the memory side.

Ports:
- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  synchronous active-high reset
- i_p_req  in  1  pipeline memory access request
- i_p_wren  in  1  pipeline: 1 = write, 0 = read
- i_p_addr  in  ADDR_W  pipeline byte address
- i_p_wdata  in  32  pipeline store data
- i_p_bmask  in  4  pipeline byte enables
- o_p_stall  out  1  pipeline request not granted this cycle
- o_p_rvalid  out  1  pipeline read data valid
- o_p_rdata  out  32  pipeline read data
- i_d_req  in  1  debug request; held stable until granted
- i_d_wren  in  1  debug: 1 = write
- i_d_addr  in  ADDR_W  debug address
- i_d_wdata  in  32  debug store data
- i_d_bmask  in  4  debug byte enables
- i_d_lock  in  1  debug requests exclusive memory ownership
- o_d_gnt  out  1  debug request accepted this cycle
- o_d_rvalid  out  1  debug read data valid
- o_d_rdata  out  32  debug read data
- o_m_req  out  1  memory access strobe
- o_m_wren  out  1  memory write enable
- o_m_addr  out  ADDR_W  memory address
- o_m_wdata  out  32  memory write data
- o_m_bmask  out  4  memory byte enables
- i_m_rdata  in  32  memory read data, valid exactly 1 cycle after a read strobe

Behaviour:
- Reset is synchronous, active-high, on i_clk. While i_rst=1:
  - state=ARB, starve_cnt=0, owner tag cleared.
  - o_m_req=0, o_p_stall=0, o_d_gnt=0, o_p_rvalid=0, o_d_rvalid=0, o_p_rdata=0, o_d_rdata=0.
  - Any read in flight when reset asserts is dropped; no rvalid follows reset release.
- At most one grant per cycle. Grant is combinational from current state and requests.
- o_m_* is a combinational mux of the granted port. When nothing is granted: o_m_req=0 and the other o_m_* outputs are 0.
- State ARB:
  - Grant D if i_d_req and (~i_p_req or starve_cnt==STARVE_MAX). Otherwise grant P if i_p_req.
- State LOCK:
  - P is never granted. D is granted whenever i_d_req=1.
- o_p_stall = i_p_req & ~grant_p. o_d_gnt = grant_d.
- The pipeline holds its request stable while stalled. The arbiter does not latch P request fields.
- FSM transitions:
  - ARB->LOCK at the clock edge where grant_d=1 and i_d_lock=1.
  - LOCK->ARB at the first edge where i_d_lock=0; P is eligible in the following cycle.
  - i_d_lock without a D grant has no effect.
- starve_cnt (8 bits, saturating at STARVE_MAX):
  - Increments when i_d_req=1 and D is not granted.
  - Clears when D is granted or i_d_req=0.
  - Frozen at 0 in LOCK.
- Read response:
  - A granted read (wren=0) registers the owner tag (P or D).
  - Next cycle, the owner's rvalid=1 and its rdata=i_m_rdata. The other port's rvalid=0 and rdata=0.
  - Writes produce no rvalid.
  - Back-to-back reads from alternating owners are allowed; each response goes to its own tag.
- Simultaneous P and D requests with starve_cnt<STARVE_MAX: P wins and starve_cnt increments.
- STARVE_MAX=1 gives strict alternation under continuous contention.

Test Plan:
1. Reset held 3 cycles with i_p_req=1, i_d_req=1 -> o_m_req=0, o_p_stall=0, o_d_gnt=0, both rvalid=0. First cycle after release: P granted, o_p_stall=0.
2. P read addr 0x100, memory returns 0xDEADBEEF next cycle -> o_p_rvalid=1 and o_p_rdata=0xDEADBEEF one cycle after grant; o_d_rvalid=0.
3. P and D requesting continuously, STARVE_MAX=8 -> P granted 8 cycles, D granted on the 9th with o_p_stall=1 that cycle. Pattern repeats every 9 cycles.
4. D write 0x12345678 to 0x200 with bmask=0xF while P idle -> o_d_gnt=1 same cycle; o_m_addr=0x200, o_m_wren=1; no rvalid.
5. D granted with i_d_lock=1 for 5 cycles while P requests -> o_p_stall=1 throughout. After i_d_lock drops, P is granted on the next cycle.
6. i_rst asserted the cycle after a D read grant -> o_d_rvalid stays 0; starve_cnt and state return to 0/ARB.
